div_4bit_seq: RTL and testbench

//  Sequential restoring divider; the inverse operation of the team's 4-bit array multiplier.

---
 rtl/div_4bit_seq.sv | 130 +++++++++++++
 tb/tb_div_4bit_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_4bit_seq.sv
// Sequential restoring divider: one quotient bit per clock under a start/done handshake.
// Optional DIV_ZERO_FLAG_EN adds the dz output and a fast path for a zero divisor.
module div_4bit_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             dz
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] q_new;
    logic             last;
    logic             skip;
    logic             accept;
    logic             busy_nxt;
    logic             done_nxt;

    // One restoring step; partial remainder stays below divisor, so the borrow bit is the compare.
    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        diff  = r_sh - {1'b0, dvs};
        ge    = ~diff[WIDTH];
        r_new = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_new = {q[WIDTH-2:0], ge};
    end

`ifdef DIV_ZERO_FLAG_EN
    assign skip = (dvs == '0);
`else
    assign skip = 1'b0;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last || skip) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    busy_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            r         <= '0;
            q         <= '0;
            dvs       <= '0;
            cnt       <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz        <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (accept) begin
                r   <= '0;
                q   <= dividend;
                dvs <= divisor;
                cnt <= '0;
            end else if (state == RUN) begin
                r   <= r_new;
                q   <= q_new;
                cnt <= cnt + CW'(1);
            end
            // On the skip path q still holds the untouched dividend
            if (done_nxt) begin
                quotient  <= skip ? '1 : q_new;
                remainder <= skip ? q : r_new;
`ifdef DIV_ZERO_FLAG_EN
                dz        <= skip;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Scoreboard bench for div_4bit_seq: expectations queued at launch, compared on each done pulse.
module tb_div_4bit_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic       dz;
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 5;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    div_4bit_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz        (dz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void expect_div(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.q = (b == 4'd0) ? 4'd15 : 4'(a / b);
        e.r = (b == 4'd0) ? a : 4'(a % b);
        sb.push_back(e);
    endfunction

    // Compare every done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("quotient", int'(quotient), int'(mon_e.q));
                check_eq("remainder", int'(remainder), int'(mon_e.r));
                if (mon_e.b != 4'd0) begin
                    check_eq("invariant", int'(quotient) * int'(mon_e.b) + int'(remainder), int'(mon_e.a));
                    check_eq("rem_lt_div", int'(remainder < mon_e.b), 1);
                end
`ifdef DIV_ZERO_FLAG_EN
                check_eq("dz", int'(dz), int'(mon_e.b == 4'd0));
`endif
            end
        end
    end

    // Drive one accepted start; returns at the negedge just after the accept edge
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        expect_div(a, b);
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    // lat0 = cycles since accept at the current negedge; checks latency and busy duration
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat = lat0;
        int nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy_cycles"}, nb, exp_lat - lat0);
        check_eq({tag, "_busy_at_done"}, int'(busy), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_lat;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_quotient", int'(quotient), 0);
        check_eq("rst_remainder", int'(remainder), 0);
        rst = 1'b0;

        launch(4'd13, 4'd3);
        wait_done("t1", 1, 5);

        launch(4'd15, 4'd1);
        wait_done("t2a", 1, 5);
        launch(4'd0, 4'd5);
        wait_done("t2b", 1, 5);
        launch(4'd7, 4'd9);
        wait_done("t2c", 1, 5);
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_quotient", int'(quotient), 0);
            check_eq("hold_remainder", int'(remainder), 7);
            check_eq("hold_done", int'(done), 0);
        end

        launch(4'd9, 4'd0);
        wait_done("t3", 1, ZLAT);

        // Start pulse in the 2nd RUN cycle must be ignored
        launch(4'd14, 4'd4);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        wait_done("t4a", 3, 5);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        expect_div(4'd6, 4'd2);
        @(negedge clk);
        start    = 1'b0;
        wait_done("t4b", 1, 5);

        // Reset during the 3rd RUN cycle aborts the division
        launch(4'd11, 4'd2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_quotient", int'(quotient), 0);
        check_eq("abort_remainder", int'(remainder), 0);
        sb.delete();
        repeat (6) @(negedge clk);
        check_eq("abort_idle_busy", int'(busy), 0);
        launch(4'd10, 4'd3);
        wait_done("t5", 1, 5);

        // Exhaustive back-to-back sweep, start held high through each DONE
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            dividend = 4'(i >> 4);
            divisor  = 4'(i);
            start    = 1'b1;
            expect_div(dividend, divisor);
            exp_lat  = (divisor == 4'd0) ? ZLAT : 5;
            @(negedge clk);
            n = 1;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check_eq("sweep_lat", n, exp_lat);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
